// File: rtl/sevseg_scroll_ctrl.sv
// sevseg_scroll_ctrl: scrolls a nibble message buffer across an 8-digit seven-segment display
module sevseg_scroll_ctrl #(
  parameter int MSG_DEPTH = 32,
  localparam int AW = $clog2(MSG_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [3:0]    i_wr_data,
  input  logic [AW:0]   i_len,
  input  logic [31:0]   i_step,
  input  logic          i_loop,
  input  logic          i_start,
  input  logic          i_stop,
  output logic [7:0]    o_enables,
  output logic [31:0]   o_digits,
  output logic [AW-1:0] o_pos,
  output logic          o_busy,
  output logic          o_done
);
  typedef enum logic {IDLE, SCROLL} state_t;
  localparam logic [AW:0] DEPTH = (AW+1)'(MSG_DEPTH);
  state_t state;
  logic [3:0] mem [MSG_DEPTH];
  logic [AW:0] len_q, len_in, idx;
  logic [31:0] step_q, cnt_q, step_in;
  logic loop_q, last, lit;
  logic [31:0] dig_n;
  logic [7:0] en_n;
  assign len_in = (i_len > DEPTH) ? DEPTH : i_len;
  assign step_in = (i_step == '0) ? 32'd1 : i_step;
  assign last = ({1'b0, o_pos} == len_q - 1'b1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= '0;
    else if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      len_q <= '0;
      step_q <= '0;
      loop_q <= 1'b0;
      cnt_q <= '0;
      o_pos <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE) begin
        if (i_start && !i_stop && i_len != '0) begin
          state <= SCROLL;
          len_q <= len_in;
          step_q <= step_in;
          loop_q <= i_loop;
          cnt_q <= step_in - 1'b1;
          o_pos <= '0;
          o_busy <= 1'b1;
        end
      end else if (i_stop) begin
        state <= IDLE;
        o_pos <= '0;
        o_busy <= 1'b0;
      end else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else begin
        cnt_q <= step_q - 1'b1;
        if (!last) o_pos <= o_pos + 1'b1;
        else if (loop_q) o_pos <= '0;
        else begin
          state <= IDLE;
          o_pos <= '0;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  always_comb begin
    dig_n = '0;
    en_n = '1;
    idx = '0;
    lit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = {1'b0, o_pos} + (AW+1)'(7 - k);
      if (loop_q) for (int j = 0; j < 8; j++) idx = (idx >= len_q) ? idx - len_q : idx;
      lit = loop_q || (idx < len_q);
      dig_n[4*k +: 4] = lit ? mem[idx[AW-1:0]] : 4'h0;
      en_n[k] = !lit;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_enables <= 8'hFF;
      o_digits <= '0;
    end else begin
      o_enables <= (state == SCROLL) ? en_n : 8'hFF;
      o_digits <= (state == SCROLL) ? dig_n : '0;
    end
endmodule

// File: tb/tb_sevseg_scroll_ctrl.sv
// tb_sevseg_scroll_ctrl: scoreboard bench for the seven-segment scroll sequencer
module tb_sevseg_scroll_ctrl;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [AW:0] len = '0;
  logic [31:0] step = '0;
  logic loop_m = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [7:0] enables;
  logic [31:0] digits;
  logic [AW-1:0] pos;
  logic busy, done;
  logic [3:0] mdl [DEPTH];
  logic [39:0] sb [$];
  logic [39:0] cap [64];
  int total = 0;
  int bad = 0;

  sevseg_scroll_ctrl #(.MSG_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_len(len), .i_step(step), .i_loop(loop_m), .i_start(start), .i_stop(stop),
    .o_enables(enables), .o_digits(digits), .o_pos(pos), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] exp_win(int p, int l, bit lp, bit act);
    logic [31:0] d;
    logic [7:0] e;
    int idx;
    d = '0;
    e = '1;
    if (act) for (int k = 0; k < 8; k++) begin
      idx = p + 7 - k;
      if (lp) idx = idx % l;
      if (lp || idx < l) begin
        d[4*k +: 4] = mdl[idx];
        e[k] = 1'b0;
      end
    end
    return {e, d};
  endfunction

  task automatic wr(int a, logic [3:0] v);
    wr_en = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = v;
    tick();
    wr_en = 1'b0;
    mdl[a] = v;
  endtask

  task automatic go(int l, int s, bit lp);
    len = l[AW:0];
    step = s;
    loop_m = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(int l, int s, bit lp, int ncyc, int poke, int wn, int wa, logic [3:0] wd);
    int st, pe;
    bit act;
    logic [39:0] got, ex;
    st = (s == 0) ? 1 : s;
    sb.delete();
    sb.push_back(exp_win(0, l, lp, 1'b1));
    cap[0] = {enables, digits};
    for (int n = 1; n <= ncyc; n++) begin
      if (n == poke) begin
        start = 1'b1;
        len = 6'd5;
        step = 32'd1;
        loop_m = 1'b1;
      end
      if (n == wn) begin
        wr_en = 1'b1;
        wr_addr = wa[AW-1:0];
        wr_data = wd;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (n == wn) mdl[wa] = wd;
      act = lp || (n < l * st);
      pe = (n / st) % l;
      got = {enables, digits};
      cap[n] = got;
      ex = sb.pop_front();
      total++;
      if (got !== ex) begin
        bad++;
        $display("FAIL window cyc=%0d got=%h exp=%h", n, got, ex);
      end
      total++;
      if (busy !== act) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", n, busy, act);
      end
      total++;
      if (done !== (!lp && n == l * st)) begin
        bad++;
        $display("FAIL done cyc=%0d got=%b exp=%b", n, done, (!lp && n == l * st));
      end
      if (act) begin
        total++;
        if (pos !== pe[AW-1:0]) begin
          bad++;
          $display("FAIL pos cyc=%0d got=%0d exp=%0d", n, pos, pe);
        end
      end
      sb.push_back(exp_win(pe, l, lp, act));
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 4'h0;
    #12;
    total++;
    if ({busy, done, pos, enables, digits} !== {1'b0, 1'b0, 5'd0, 8'hFF, 32'h0}) begin
      bad++;
      $display("FAIL reset_state got=%b%b %0d %h %h exp=00 0 ff 00000000", busy, done, pos, enables, digits);
    end
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || enables !== 8'hFF) begin
      bad++;
      $display("FAIL reset_idle got busy=%b en=%h exp busy=0 en=ff", busy, enables);
    end
  endtask

  task automatic test_single_pass();
    for (int i = 0; i < 8; i++) wr(i, 4'(i + 1));
    go(8, 4, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL sp_busy_rise got=%b exp=1", busy);
    end
    run(8, 4, 1'b0, 34, 0, 0, 0, 4'h0);
    total++;
    if (cap[1] !== {8'h00, 32'h12345678}) begin
      bad++;
      $display("FAIL sp_first got=%h exp=0012345678", cap[1]);
    end
    total++;
    if (cap[5] !== {8'h01, 32'h23456780}) begin
      bad++;
      $display("FAIL sp_second got=%h exp=0123456780", cap[5]);
    end
    total++;
    if (cap[33] !== {8'hFF, 32'h0}) begin
      bad++;
      $display("FAIL sp_blank got=%h exp=ff00000000", cap[33]);
    end
  endtask

  task automatic test_loop_stop();
    wr(0, 4'hA);
    wr(1, 4'hB);
    wr(2, 4'hC);
    go(3, 2, 1'b1);
    run(3, 2, 1'b1, 8, 0, 0, 0, 4'h0);
    total++;
    if ({cap[1], cap[3], cap[5], cap[7]} !== {8'h00, 32'hABCABCAB, 8'h00, 32'hBCABCABC, 8'h00, 32'hCABCABCA, 8'h00, 32'hABCABCAB}) begin
      bad++;
      $display("FAIL loop_windows got=%h %h %h %h", cap[1], cap[3], cap[5], cap[7]);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if ({busy, done, pos} !== {1'b0, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL stop_state got busy=%b done=%b pos=%0d exp 0 0 0", busy, done, pos);
    end
    tick();
    total++;
    if ({done, enables, digits} !== {1'b0, 8'hFF, 32'h0}) begin
      bad++;
      $display("FAIL stop_blank got done=%b en=%h dig=%h", done, enables, digits);
    end
  endtask

  task automatic test_step_zero();
    go(10, 0, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL step0_busy got=%b exp=1", busy);
    end
    run(10, 0, 1'b0, 12, 0, 0, 0, 4'h0);
  endtask

  task automatic test_start_edges();
    go(0, 3, 1'b0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_len0 got busy=%b exp=0", busy);
    end
    stop = 1'b1;
    go(8, 3, 1'b0);
    stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_with_stop got busy=%b exp=0", busy);
    end
    tick();
    go(8, 2, 1'b0);
    run(8, 2, 1'b0, 20, 3, 0, 0, 4'h0);
  endtask

  task automatic test_midscroll_write();
    for (int i = 0; i < 8; i++) wr(i, 4'(i + 1));
    go(8, 4, 1'b0);
    run(8, 4, 1'b0, 34, 0, 6, 3, 4'hF);
    total++;
    if (cap[6] !== {8'h01, 32'h23456780}) begin
      bad++;
      $display("FAIL wr_before got=%h exp=0123456780", cap[6]);
    end
    total++;
    if (cap[7] !== {8'h01, 32'h23F56780}) begin
      bad++;
      $display("FAIL wr_after got=%h exp=0123f56780", cap[7]);
    end
  endtask

  task automatic test_async_reset();
    go(8, 4, 1'b1);
    run(8, 4, 1'b1, 5, 0, 0, 0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, pos, enables, digits} !== {1'b0, 1'b0, 5'd0, 8'hFF, 32'h0}) begin
      bad++;
      $display("FAIL async_reset got=%b%b %0d %h %h exp=00 0 ff 00000000", busy, done, pos, enables, digits);
    end
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 4'h0;
    tick();
    go(8, 1, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_start got busy=%b exp=1", busy);
    end
    run(8, 1, 1'b0, 10, 0, 0, 0, 4'h0);
    total++;
    if (cap[1] !== {8'h00, 32'h0}) begin
      bad++;
      $display("FAIL post_reset_zero got=%h exp=0000000000", cap[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_loop_stop();
    test_step_zero();
    test_start_edges();
    test_midscroll_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
